comparator_bist: RTL and testbench

- Synthesizable self-checking driver/checker for the N-bit magnitude comparator (operand inputs a/b; results eq/gt/lt).
- Acts as the initiator end of the comparator interface: drives every operand pair exhaustively, samples eq/gt/lt, checks against golden results and reports pass/fail.
- Used for on-chip BIST and FPGA bring-up of comparator instances.

---
 rtl/comparator_bist.sv | 135 +++++++++++++
 tb/tb_comparator_bist.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_bist.sv
// Exhaustive BIST initiator for an N-bit magnitude comparator: sweeps every {a,b} pair,
// checks eq/gt/lt against golden results. Define CMP_BIST_STOP_ON_FAIL_EN to end at the first mismatch.
module comparator_bist #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 eq_in,
    input  logic                 gt_in,
    input  logic                 lt_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [2*WIDTH-1:0]   fail_vec
);

    localparam int VW = 2 * WIDTH;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [VW-1:0]   vec;
    logic [VW-1:0]   vec_next;
    logic            exp_eq, exp_gt, exp_lt;
    logic            mismatch;
    logic            last_vec;
    logic            settled;
    logic [ERR_W-1:0] err_inc;

    // The operand registers are the vector counter; a separate copy would only duplicate them.
    assign vec      = {a_out, b_out};
    assign vec_next = vec + VW'(1);
    assign last_vec = &vec;
    assign settled  = (settle_cnt == SW'(SETTLE - 1));

    assign exp_eq   = (a_out == b_out);
    assign exp_gt   = (a_out >  b_out);
    assign exp_lt   = (a_out <  b_out);
    assign mismatch = ({eq_in, gt_in, lt_in} != {exp_eq, exp_gt, exp_lt});
    assign err_inc  = (&err_count) ? err_count : err_count + ERR_W'(1);

    // NOTE: all state and outputs update with non-blocking assignments so every branch
    // below sees the pre-edge values of err_count/vec, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            a_out      <= '0;
            b_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_out      <= '0;
                        b_out      <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (settled) begin
                        settle_cnt <= '0;
                        state      <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_CHECK: begin
`ifdef CMP_BIST_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        err_count <= ERR_W'(1);
                        fail_vec  <= vec;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        state     <= S_DONE;
                    end else if (last_vec) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        a_out <= vec_next[VW-1:WIDTH];
                        b_out <= vec_next[WIDTH-1:0];
                        state <= S_WAIT;
                    end
`else
                    if (mismatch) begin
                        err_count <= err_inc;
                        // A saturating counter never returns to zero, so zero means "no failure yet".
                        if (err_count == '0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (last_vec) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                        state <= S_DONE;
                    end else begin
                        a_out <= vec_next[VW-1:WIDTH];
                        b_out <= vec_next[WIDTH-1:0];
                        state <= S_WAIT;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_bist.sv
// Scoreboard bench for comparator_bist: two instances (WIDTH=1/SETTLE=1, WIDTH=2/SETTLE=2)
// drive a behavioural comparator with selectable faults; expected results come from a sweep model.
module tb_comparator_bist;

    typedef struct {
        int lat;
        int pass;
        int errs;
        int fvec;
        int start_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start1, start2;
    int   mode1, mode2;
    logic [15:0] rmask1, rmask2;

    logic [0:0]  u1_a, u1_b;
    logic        u1_eq, u1_gt, u1_lt, u1_busy, u1_done, u1_pass;
    logic [15:0] u1_err;
    logic [1:0]  u1_fail;

    logic [1:0]  u2_a, u2_b;
    logic        u2_eq, u2_gt, u2_lt, u2_busy, u2_done, u2_pass;
    logic [15:0] u2_err;
    logic [3:0]  u2_fail;

    int   cyc;
    int   checks;
    int   errors;
    exp_t q1[$];
    exp_t q2[$];

    comparator_bist #(.WIDTH(1), .SETTLE(1), .ERR_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_out(u1_a), .b_out(u1_b),
        .eq_in(u1_eq), .gt_in(u1_gt), .lt_in(u1_lt),
        .busy(u1_busy), .done(u1_done), .pass(u1_pass),
        .err_count(u1_err), .fail_vec(u1_fail)
    );

    comparator_bist #(.WIDTH(2), .SETTLE(2), .ERR_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a_out(u2_a), .b_out(u2_b),
        .eq_in(u2_eq), .gt_in(u2_gt), .lt_in(u2_lt),
        .busy(u2_busy), .done(u2_done), .pass(u2_pass),
        .err_count(u2_err), .fail_vec(u2_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator under test: mode 0 correct, 1 eq stuck-at-0, 2 gt/lt swapped, 3 eq flipped where mask bit set.
    function automatic logic [2:0] dev_out(input int mode, input int a, input int b, input int idx,
                                           input logic [15:0] m);
        logic eq, gt, lt, t;
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
        case (mode)
            1: eq = 1'b0;
            2: begin t = gt; gt = lt; lt = t; end
            3: if (m[idx[3:0]]) eq = ~eq;
            default: ;
        endcase
        return {eq, gt, lt};
    endfunction

    always_comb {u1_eq, u1_gt, u1_lt} = dev_out(mode1, int'(u1_a), int'(u1_b), int'({u1_a, u1_b}), rmask1);
    always_comb {u2_eq, u2_gt, u2_lt} = dev_out(mode2, int'(u2_a), int'(u2_b), int'({u2_a, u2_b}), rmask2);

    function automatic exp_t ref_model(input int w, input int s, input int mode, input logic [15:0] m);
        exp_t e;
        int n, first, a, b;
        logic [2:0] gold, got;
        n = 1 << (2 * w);
        e.errs = 0;
        e.lat = (s + 1) * n;
        first = -1;
        for (int v = 0; v < n; v++) begin
            a = v >> w;
            b = v % (1 << w);
            gold = {a == b, a > b, a < b};
            got = dev_out(mode, a, b, v, m);
            if (got != gold) begin
                e.errs++;
                if (first < 0) first = v;
`ifdef CMP_BIST_STOP_ON_FAIL_EN
                e.lat = (s + 1) * (v + 1);
                break;
`endif
            end
        end
        e.pass = (e.errs == 0) ? 1 : 0;
        e.fvec = (first < 0) ? 0 : first;
        e.start_edge = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the WIDTH=1 instance: pops the scoreboard on each rising done.
    initial begin : mon1
        int busy_cnt;
        logic done_prev;
        exp_t e;
        busy_cnt = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                done_prev = 1'b0;
            end else begin
                if (u1_busy) busy_cnt++;
                if (u1_done && !done_prev) begin
                    if (q1.size() == 0) begin
                        check("u1_spurious_done", u1_done, 0);
                    end else begin
                        e = q1.pop_front();
                        check("u1_latency", cyc - e.start_edge, e.lat);
                        check("u1_busy_cycles", busy_cnt, e.lat);
                        check("u1_pass", u1_pass, e.pass);
                        check("u1_err_count", u1_err, e.errs);
                        check("u1_fail_vec", u1_fail, e.fvec);
                        check("u1_last_vec", {u1_a, u1_b}, e.lat / 2 - 1);
                    end
                    busy_cnt = 0;
                end
                done_prev = u1_done;
            end
        end
    end

    // Monitor for the WIDTH=2 instance: result scoreboard plus per-vector order and hold time.
    initial begin : mon2
        logic done_prev, tracking;
        int hold, cur;
        exp_t e;
        done_prev = 1'b0;
        tracking = 1'b0;
        hold = 0;
        cur = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_prev = 1'b0;
                tracking = 1'b0;
            end else begin
                if (u2_busy) begin
                    if (!tracking) begin
                        tracking = 1'b1;
                        cur = int'({u2_a, u2_b});
                        hold = 1;
                        check("u2_first_vec", cur, 0);
                    end else if (int'({u2_a, u2_b}) == cur) begin
                        hold++;
                    end else begin
                        check("u2_hold", hold, 3);
                        check("u2_order", {u2_a, u2_b}, cur + 1);
                        cur = int'({u2_a, u2_b});
                        hold = 1;
                    end
                end else if (tracking) begin
                    check("u2_last_hold", hold, 3);
                    tracking = 1'b0;
                end
                if (u2_done && !done_prev) begin
                    if (q2.size() == 0) begin
                        check("u2_spurious_done", u2_done, 0);
                    end else begin
                        e = q2.pop_front();
                        check("u2_latency", cyc - e.start_edge, e.lat);
                        check("u2_pass", u2_pass, e.pass);
                        check("u2_err_count", u2_err, e.errs);
                        check("u2_fail_vec", u2_fail, e.fvec);
                        check("u2_last_vec", {u2_a, u2_b}, e.lat / 3 - 1);
                    end
                end
                done_prev = u2_done;
            end
        end
    end

    task automatic launch(input int inst, input int mode, input logic [15:0] m, input bit mid, input bit clr);
        exp_t e;
        @(negedge clk);
        if (inst == 1) begin
            mode1 = mode;
            rmask1 = m;
            e = ref_model(1, 1, mode, m);
        end else begin
            mode2 = mode;
            rmask2 = m;
            e = ref_model(2, 2, mode, m);
        end
        e.start_edge = cyc + 1;
        if (inst == 1) begin
            q1.push_back(e);
            start1 = 1'b1;
        end else begin
            q2.push_back(e);
            start2 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        if (clr) begin
            if (inst == 1) check("u1_restart_clear", {u1_done, u1_busy, u1_err, u1_fail}, 32'h40000);
            else           check("u2_restart_clear", {u2_done, u2_busy, u2_err, u2_fail}, 32'h100000);
        end
        if (mid) begin
            repeat (2) @(negedge clk);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
    endtask

    task automatic wait_done(input int inst);
        int n;
        n = 0;
        while (!(inst == 1 ? u1_done : u2_done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(inst == 1 ? "u1_done_seen" : "u2_done_seen", inst == 1 ? u1_done : u2_done, 1);
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        mode1 = 0;
        mode2 = 0;
        rmask1 = '0;
        rmask2 = '0;
        #12;
        check("u1_reset_state", {u1_a, u1_b, u1_busy, u1_done, u1_pass, u1_err, u1_fail}, 0);
        check("u2_reset_state", {u2_a, u2_b, u2_busy, u2_done, u2_pass, u2_err, u2_fail}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(1, 0, 16'h0, 1'b1, 1'b0);
        wait_done(1);
        launch(1, 1, 16'h0, 1'b0, 1'b0);
        wait_done(1);
        launch(1, 0, 16'h0, 1'b0, 1'b1);
        wait_done(1);
        launch(1, 2, 16'h0, 1'b0, 1'b0);
        wait_done(1);

        launch(1, 0, 16'h0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("u1_async_reset", {u1_a, u1_b, u1_busy, u1_done, u1_pass, u1_err, u1_fail}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        q1.delete();
        repeat (5) @(negedge clk);
        check("u1_idle_after_reset", {u1_a, u1_b, u1_busy, u1_done}, 0);
        launch(1, 0, 16'h0, 1'b0, 1'b0);
        wait_done(1);

        for (int i = 0; i < 4; i++) begin
            launch(1, 3, 16'($urandom_range(0, 15)), 1'b0, 1'b0);
            wait_done(1);
        end

        launch(2, 0, 16'h0, 1'b0, 1'b0);
        wait_done(2);
        for (int i = 0; i < 3; i++) begin
            launch(2, 3, 16'($urandom_range(0, 65535)), 1'b0, i == 0);
            wait_done(2);
        end

        repeat (3) @(negedge clk);
        check("u1_scoreboard_drained", q1.size(), 0);
        check("u2_scoreboard_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
